uart_avmm_host: RTL and testbench
=================================

// Module: uart_avmm_host
// PURPOSE
//  Avalon-MM initiator driving uart_core's slave port: drains a local TX byte FIFO into TXDATA
//  with status-poll flow control and, on IRQ_event, reads received bytes out to a valid/ready stream.
//  Sits between fabric logic (byte producer/consumer) and uart_core; no CPU required.
// PARAMETERS
//  TX_DEPTH      4    TX FIFO entries, power of 2, >=2
//  READ_LATENCY  1    cycles from read-issue edge to readdata valid (uart_core = 1)
//  POLL_GAP      8    idle cycles between a status poll returning not-ready and the next poll
//  IRQ_HOLDOFF   2    cycles irq_i is ignored after an RX read (irq deassert propagation)
//  POLL_TIMEOUT  4096 consecutive not-ready polls before head byte is dropped (timeout build only)
// PORTS
//  clk_i            in   1  clock
//  arst_n_i         in   1  asynchronous active-low reset
//  tx_data_i        in   8  byte to transmit
//  tx_valid_i       in   1  tx_data_i valid
//  tx_ready_o       out  1  TX FIFO not full; transfer on valid&ready
//  rx_data_o        out  8  received byte
//  rx_valid_o       out  1  rx_data_o valid; held until rx_ready_i
//  rx_ready_i       in   1  consumer accepts rx_data_o
//  rx_overrun_o     out  1  1-cycle pulse: byte read while rx_valid_o busy, byte dropped
//  tx_timeout_o     out  1  1-cycle pulse: head byte dropped on poll timeout (0 if macro off)
//  busy_o           out  1  FSM not in IDLE or FIFO non-empty
//  avm_address_o    out  4  0x0 TXDATA, 0x1 STATUS (bit0 = tx ready), 0x2 RXDATA (read clears IRQ)
//  avm_read_o       out  1  read strobe, exactly 1 cycle per access
//  avm_write_o      out  1  write strobe, exactly 1 cycle per access
//  avm_writedata_o  out  8  write data, valid only with avm_write_o
//  avm_readdata_i   in   8  read data from uart_core
//  irq_i            in   1  uart_core IRQ_event, level, RX byte pending
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0 except tx_ready_o=1; avm_address_o=0x1; FIFO empty; FSM IDLE.
//  All outputs registered. Strobes never overlap; address/writedata stable in strobe cycle.
//  FSM: IDLE, RX_RD, RX_WAIT, POLL_RD, POLL_WAIT, TX_WR, GAP.
//   IDLE: irq_i=1 and holdoff expired -> RX_RD (RX has priority); else FIFO non-empty -> POLL_RD.
//   RX_RD: read 0x2 one cycle -> RX_WAIT; sample readdata READ_LATENCY cycles after strobe.
//    rx_valid_o=0: load rx_data_o, set rx_valid_o. rx_valid_o=1: drop byte, pulse rx_overrun_o.
//    Start IRQ_HOLDOFF counter -> IDLE.
//   POLL_RD: read 0x1 -> POLL_WAIT; sampled bit0=1 -> TX_WR; bit0=0 -> GAP.
//   TX_WR: write FIFO head to 0x0 one cycle, pop same cycle -> IDLE (next byte re-polls).
//   GAP: count POLL_GAP cycles -> IDLE (IRQ may be served before re-poll).
//  rx_valid_o clears on rx_valid_o&rx_ready_i; new load and accept in same cycle: load wins, valid stays 1.
//  FIFO: push and pop same cycle when full allowed (count unchanged); pointers wrap mod TX_DEPTH.
//  tx_ready_o = !full, registered from next-state count; push ignored when full.
//  Min cost per TX byte: 1 poll + READ_LATENCY + 1 write + 1 IDLE = 4 cycles at READ_LATENCY=1.
// CONFIGURATION
//  UART_HOST_POLL_TIMEOUT_EN defined: counter of consecutive not-ready polls, cleared on ready or
//   pop; at POLL_TIMEOUT pop head without writing, pulse tx_timeout_o, counter -> 0.
//  Undefined: polls indefinitely; tx_timeout_o tied 0; no counter logic present.
// TESTING  (uart_core slave model or real uart_core, 100 MHz, 115200 baud)
//  Push 0x48,0x45,0x4C with status always ready -> 3 writes to 0x0 in order, each preceded by 1 read of 0x1.
//  Status bit0=0 for 3 polls then 1 -> 4 reads of 0x1 spaced >= POLL_GAP, then single write of byte.
//  irq_i=1 with readdata 0x6E, rx_ready_i=1 -> one read of 0x2, rx_data_o=0x6E, rx_valid_o 1 cycle.
//  rx_ready_i=0, two IRQ bytes 0xF8,0x6E -> rx_data_o holds 0xF8, rx_overrun_o pulses once.
//  Push 5 bytes with TX_DEPTH=4, status not ready -> tx_ready_o=0 after 4th, 5th push ignored.
//  arst_n_i low mid TX_WR -> strobes 0 immediately, FIFO empty; macro on + status stuck 0 ->
//   tx_timeout_o pulse after POLL_TIMEOUT polls.

Source files
------------

// File: rtl/uart_avmm_host.sv
// Avalon-MM host for uart_core: drains a TX byte FIFO and streams out IRQ-driven RX bytes.
// Define UART_HOST_POLL_TIMEOUT_EN to drop the head byte after POLL_TIMEOUT not-ready polls.
module uart_avmm_host #(
  parameter int TX_DEPTH     = 4,
  parameter int READ_LATENCY = 1,
  parameter int POLL_GAP     = 8,
  parameter int IRQ_HOLDOFF  = 2,
  parameter int POLL_TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overrun_o,
  output logic       tx_timeout_o,
  output logic       busy_o,
  output logic [3:0] avm_address_o,
  output logic       avm_read_o,
  output logic       avm_write_o,
  output logic [7:0] avm_writedata_o,
  input  logic [7:0] avm_readdata_i,
  input  logic       irq_i
);

  localparam int PW   = $clog2(TX_DEPTH);
  localparam int NW   = PW + 1;
  localparam int CMAX = (POLL_GAP > READ_LATENCY) ? POLL_GAP : READ_LATENCY;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int HW   = $clog2(IRQ_HOLDOFF + 2);

  localparam logic [3:0] A_TX = 4'h0;
  localparam logic [3:0] A_ST = 4'h1;
  localparam logic [3:0] A_RX = 4'h2;

  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 ||
      READ_LATENCY < 1 || POLL_GAP < 1 || POLL_TIMEOUT < 1) begin : g_bad_param
    $error("uart_avmm_host: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE,
    RX_RD,
    RX_WAIT,
    POLL_RD,
    POLL_WAIT,
    TX_WR,
    GAP
  } state_t;

  state_t        state;
  logic [7:0]    mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic [NW-1:0] count_nxt;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold_cnt;
  logic          push;
  logic          pop;
  logic          wait_done;

`ifdef UART_HOST_POLL_TIMEOUT_EN
  localparam int TW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(POLL_TIMEOUT - 1);
  logic [TW-1:0] to_cnt;
  logic          to_hit;
`else
  assign tx_timeout_o = 1'b0;
`endif

  always_comb begin
    push      = tx_valid_i && tx_ready_o;
    wait_done = (cnt == '0);
    pop       = (state == TX_WR);
`ifdef UART_HOST_POLL_TIMEOUT_EN
    to_hit = (state == POLL_WAIT) && wait_done &&
             !avm_readdata_i[0] && (to_cnt == TO_LIM);
    if (to_hit) pop = 1'b1;
`endif
    count_nxt = count + NW'(push) - NW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= tx_data_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tx_ready_o <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count      <= count_nxt;
      tx_ready_o <= (count_nxt != NW'(TX_DEPTH));
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state           <= IDLE;
      cnt             <= '0;
      hold_cnt        <= '0;
      rx_data_o       <= '0;
      rx_valid_o      <= 1'b0;
      rx_overrun_o    <= 1'b0;
      busy_o          <= 1'b0;
      avm_address_o   <= A_ST;
      avm_read_o      <= 1'b0;
      avm_write_o     <= 1'b0;
      avm_writedata_o <= '0;
`ifdef UART_HOST_POLL_TIMEOUT_EN
      to_cnt          <= '0;
      tx_timeout_o    <= 1'b0;
`endif
    end else begin
      avm_read_o   <= 1'b0;
      avm_write_o  <= 1'b0;
      rx_overrun_o <= 1'b0;
      busy_o       <= (count_nxt != '0);
`ifdef UART_HOST_POLL_TIMEOUT_EN
      tx_timeout_o <= 1'b0;
`endif
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (irq_i && hold_cnt == '0) begin
            state         <= RX_RD;
            avm_read_o    <= 1'b1;
            avm_address_o <= A_RX;
            busy_o        <= 1'b1;
          end else if (count != '0) begin
            state         <= POLL_RD;
            avm_read_o    <= 1'b1;
            avm_address_o <= A_ST;
            busy_o        <= 1'b1;
          end
        end
        RX_RD: begin
          state  <= RX_WAIT;
          cnt    <= CW'(READ_LATENCY - 1);
          busy_o <= 1'b1;
        end
        RX_WAIT: begin
          if (wait_done) begin
            // an accept in this same cycle frees the slot for the new byte
            if (!rx_valid_o || rx_ready_i) begin
              rx_data_o  <= avm_readdata_i;
              rx_valid_o <= 1'b1;
            end else begin
              rx_overrun_o <= 1'b1;
            end
            hold_cnt <= HW'(IRQ_HOLDOFF);
            state    <= IDLE;
          end else begin
            cnt    <= cnt - CW'(1);
            busy_o <= 1'b1;
          end
        end
        POLL_RD: begin
          state  <= POLL_WAIT;
          cnt    <= CW'(READ_LATENCY - 1);
          busy_o <= 1'b1;
        end
        POLL_WAIT: begin
          if (!wait_done) begin
            cnt    <= cnt - CW'(1);
            busy_o <= 1'b1;
          end else if (avm_readdata_i[0]) begin
            state           <= TX_WR;
            avm_write_o     <= 1'b1;
            avm_address_o   <= A_TX;
            avm_writedata_o <= mem[rd_ptr];
            busy_o          <= 1'b1;
`ifdef UART_HOST_POLL_TIMEOUT_EN
            to_cnt          <= '0;
`endif
          end else begin
`ifdef UART_HOST_POLL_TIMEOUT_EN
            if (to_hit) begin
              to_cnt       <= '0;
              tx_timeout_o <= 1'b1;
              state        <= IDLE;
            end else begin
              to_cnt <= to_cnt + TW'(1);
              state  <= GAP;
              cnt    <= CW'(POLL_GAP - 1);
              busy_o <= 1'b1;
            end
`else
            state  <= GAP;
            cnt    <= CW'(POLL_GAP - 1);
            busy_o <= 1'b1;
`endif
          end
        end
        TX_WR: begin
          state <= IDLE;
`ifdef UART_HOST_POLL_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        GAP: begin
          if (wait_done) begin
            state <= IDLE;
          end else begin
            cnt    <= cnt - CW'(1);
            busy_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_avmm_host.sv
// Scoreboard bench for uart_avmm_host with a behavioural uart_core slave.
module tb_uart_avmm_host;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_overrun;
  logic       tx_timeout;
  logic       busy;
  logic [3:0] avm_address;
  logic       avm_read;
  logic       avm_write;
  logic [7:0] avm_writedata;
  logic [7:0] avm_readdata = '0;
  logic       irq = 1'b0;

  always #5 clk = ~clk;

  uart_avmm_host dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rx_ready),
    .rx_overrun_o   (rx_overrun),
    .tx_timeout_o   (tx_timeout),
    .busy_o         (busy),
    .avm_address_o  (avm_address),
    .avm_read_o     (avm_read),
    .avm_write_o    (avm_write),
    .avm_writedata_o(avm_writedata),
    .avm_readdata_i (avm_readdata),
    .irq_i          (irq)
  );

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] rx_exp[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int tmo_cnt = 0;
  int ovl_cnt = 0;
  int last_poll = -1;
  bit poll_free = 0;
  bit gap_chk = 0;

  // slave model state
  logic [7:0] rx_src [16];
  int rx_wr = 0;
  int rx_rd = 0;
  int poll_cnt = 0;
  int ready_after = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  always @(posedge clk) begin
    int rd_n;
    rd_n = rx_rd;
    if (avm_read) begin
      if (avm_address == 4'h1) begin
        avm_readdata <= (poll_cnt >= ready_after) ? 8'h01 : 8'hFE;
        poll_cnt <= poll_cnt + 1;
      end else if (avm_address == 4'h2) begin
        avm_readdata <= rx_src[rx_rd[3:0]];
        rd_n = rx_rd + 1;
      end else begin
        avm_readdata <= 8'h00;
      end
    end
    rx_rd <= rd_n;
    irq   <= (rd_n != rx_wr);
  end

  always @(negedge clk) begin
    txn_t t;
    if (!gap_chk) last_poll = -1;
    if (arst_n) begin
      if (avm_read && avm_write) ovl_cnt++;
      if (avm_read && avm_address == 4'h1) begin
        if (gap_chk && last_poll >= 0) chk("poll_gap", cyc - last_poll, 11);
        last_poll = cyc;
      end
      if ((avm_read || avm_write) &&
          !(poll_free && avm_read && avm_address == 4'h1)) begin
        if (exp_q.size() == 0) begin
          chk("access_queued", exp_q.size(), 1);
        end else begin
          t = exp_q.pop_front();
          chk("avm_kind", {avm_write, avm_address}, {t.wr, t.addr});
          if (t.wr) chk("avm_wdata", avm_writedata, t.data);
        end
      end
      if (rx_valid && rx_ready) begin
        if (rx_exp.size() == 0) chk("rx_queued", rx_exp.size(), 1);
        else chk("rx_data", rx_data, rx_exp.pop_front());
      end
      if (rx_overrun) ovr_cnt++;
      if (tx_timeout) tmo_cnt++;
    end
  end

  task automatic exp_rd(input logic [3:0] a);
    exp_q.push_back('{wr: 1'b0, addr: a, data: 8'h00});
  endtask

  task automatic exp_wr(input logic [7:0] d);
    exp_q.push_back('{wr: 1'b1, addr: 4'h0, data: d});
  endtask

  task automatic push_byte(input logic [7:0] b);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready) break;
    end
    chk("push_ready", int'(i < 200), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy && !irq && exp_q.size() == 0) break;
    end
    chk(nm, int'(i < max), 1);
  endtask

  initial begin
    int base;
    int i;
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22;
    bytes[2] = 8'h33; bytes[3] = 8'h44;

    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_addr", avm_address, 1);
    chk("rst_read", avm_read, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {rx_overrun, tx_timeout}, 0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // three bytes, status always ready
    ready_after = poll_cnt;
    exp_rd(4'h1); exp_wr(8'h48);
    exp_rd(4'h1); exp_wr(8'h45);
    exp_rd(4'h1); exp_wr(8'h4C);
    push_byte(8'h48);
    push_byte(8'h45);
    push_byte(8'h4C);
    wait_idle("idle_tx3", 200);

    // three not-ready polls, then ready
    gap_chk = 1;
    ready_after = poll_cnt + 3;
    repeat (4) exp_rd(4'h1);
    exp_wr(8'h5A);
    push_byte(8'h5A);
    wait_idle("idle_poll", 300);
    gap_chk = 0;

    // single RX byte, consumer ready
    rx_ready = 1'b1;
    exp_rd(4'h2);
    rx_exp.push_back(8'h6E);
    rx_src[rx_wr[3:0]] = 8'h6E;
    rx_wr = rx_wr + 1;
    for (i = 0; i < 100; i++) begin
      if (rx_valid) break;
      @(negedge clk);
    end
    chk("rx_seen", int'(i < 100), 1);
    @(negedge clk);
    chk("rx_valid_1cyc", rx_valid, 0);
    wait_idle("idle_rx1", 100);

    // two RX bytes, consumer stalled
    rx_ready = 1'b0;
    base = ovr_cnt;
    exp_rd(4'h2); exp_rd(4'h2);
    rx_exp.push_back(8'hF8);
    rx_src[rx_wr[3:0]] = 8'hF8;
    rx_src[4'((rx_wr + 1) % 16)] = 8'h6E;
    rx_wr = rx_wr + 2;
    wait_idle("idle_rx2", 200);
    repeat (2) @(negedge clk);
    chk("rx_hold_data", rx_data, 8'hF8);
    chk("rx_hold_valid", rx_valid, 1);
    chk("rx_overrun_cnt", ovr_cnt - base, 1);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rx_drained", rx_exp.size(), 0);

    // fill FIFO with status stuck not-ready
    poll_free = 1;
    ready_after = poll_cnt + 1000000;
    for (int k = 0; k < 4; k++) exp_wr(bytes[k]);
    @(negedge clk);
    tx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_data = bytes[k];
      @(negedge clk);
    end
    chk("tx_full_ready", tx_ready, 0);
    chk("tx_full_busy", busy, 1);
    tx_data = 8'h99;
    repeat (3) @(negedge clk);
    chk("tx_full_hold", tx_ready, 0);
    tx_valid = 1'b0;
    ready_after = 0;
    wait_idle("idle_fill", 500);
    repeat (20) @(negedge clk);
    poll_free = 0;
    chk("fill_done", exp_q.size(), 0);

    // reset while a write strobe is out
    ready_after = poll_cnt;
    exp_rd(4'h1); exp_wr(8'h33);
    push_byte(8'h33);
    push_byte(8'h34);
    for (i = 0; i < 100; i++) begin
      if (avm_write) break;
      @(negedge clk);
    end
    chk("wr_seen", int'(i < 100), 1);
    #1 arst_n = 1'b0;
    #1;
    chk("arst_write", avm_write, 0);
    chk("arst_read", avm_read, 0);
    chk("arst_tx_ready", tx_ready, 1);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_q", exp_q.size(), 0);

`ifdef UART_HOST_POLL_TIMEOUT_EN
    poll_free = 1;
    ready_after = poll_cnt + 1000000;
    base = tmo_cnt;
    push_byte(8'h77);
    for (i = 0; i < 60000; i++) begin
      @(negedge clk);
      if (tmo_cnt != base) break;
    end
    chk("timeout_pulse", tmo_cnt - base, 1);
    wait_idle("idle_timeout", 50);
    poll_free = 0;
`else
    chk("timeout_never", tmo_cnt, 0);
`endif
    chk("strobe_overlap", ovl_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
